sec_encoder32: RTL and testbench

Pipelined single-error-correcting check-bit generator for 32-bit data words. It produces the 8 check bits that the c499-style locked SEC corrector consumes, so that the corrector sees a zero syndrome on an uncorrupted word. It sits on the transmit/write side of the SEC channel and has a valid/ready stream interface. A per-word single-bit fault injector lets benches exercise the corrector's correction paths.

---
 rtl/sec_encoder32_if.sv | 32 +++
 rtl/sec_encoder32.sv | 147 ++++++++++++++
 tb/tb_sec_encoder32.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sec_encoder32_if.sv
// sec_encoder32_if
//   Stream bundle between a word producer, the sec_encoder32 check-bit
//   generator and the downstream consumer.
//   in_valid/in_ready/in_data : input word handshake (32-bit data)
//   inj_en/inj_pos            : per-word single-bit fault injection request
//   out_valid/out_ready       : output codeword handshake
//   out_data/out_chk          : 32-bit data (after any flip) and 8 check bits
//   enc_count                 : saturating count of completed output handshakes
//   modport slave  : the encoder side
//   modport master : the producer/consumer side (e.g. a testbench)
interface sec_encoder32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        inj_en;
  logic [5:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_chk;
  logic [15:0] enc_count;

  modport slave (
    input  in_valid, in_data, inj_en, inj_pos, out_ready,
    output in_ready, out_valid, out_data, out_chk, enc_count
  );

  modport master (
    output in_valid, in_data, inj_en, inj_pos, out_ready,
    input  in_ready, out_valid, out_data, out_chk, enc_count
  );
endinterface

// File: rtl/sec_encoder32.sv
// sec_encoder32
//   Two-stage pipelined generator of the 8 check bits consumed by the
//   locked SEC corrector, with an optional single-bit flip per word.
//   Stage A captures the word, its nibble parities G[0..7] and column
//   parities C[0..3] (low half) / H[0..3] (high half), plus the injection
//   request. Stage B combines them into the check bits, applies the flip
//   and presents the codeword.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-high reset; flushes all words in flight
//     bus : sec_encoder32_if.slave stream interface (see interface header)
module sec_encoder32 (
  input  logic            clk,
  input  logic            rst,
  sec_encoder32_if.slave  bus
);

  // Global advance: the whole pipe moves unless the output is blocked.
  logic adv;
  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  logic in_fire;
  assign in_fire = bus.in_valid & adv;

  // Parities of the incoming word.
  logic [7:0] in_g;
  logic [3:0] in_c;
  logic [3:0] in_h;

  // NOTE: every signal assigned in an always_comb gets a default first so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    in_g = '0;
    in_c = '0;
    in_h = '0;
    for (int g = 0; g < 8; g++) begin
      in_g[g] = ^bus.in_data[4*g +: 4];
    end
    for (int j = 0; j < 4; j++) begin
      in_c[j] = bus.in_data[j]    ^ bus.in_data[j+4]  ^ bus.in_data[j+8]  ^ bus.in_data[j+12];
      in_h[j] = bus.in_data[16+j] ^ bus.in_data[20+j] ^ bus.in_data[24+j] ^ bus.in_data[28+j];
    end
  end

  // Out-of-range positions (40..63) are folded into "no injection" here so
  // stage B only ever sees a valid flip target.
  logic in_inj_v;
  assign in_inj_v = bus.inj_en & (bus.inj_pos < 6'd40);

  // Stage A registers.
  logic        a_valid;
  logic [31:0] a_d;
  logic [7:0]  a_g;
  logic [3:0]  a_c;
  logic [3:0]  a_h;
  logic        a_inj_v;
  logic [5:0]  a_inj_pos;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_d       <= '0;
      a_g       <= '0;
      a_c       <= '0;
      a_h       <= '0;
      a_inj_v   <= 1'b0;
      a_inj_pos <= '0;
    end else if (adv) begin
      a_valid <= in_fire;
      if (in_fire) begin
        a_d       <= bus.in_data;
        a_g       <= in_g;
        a_c       <= in_c;
        a_h       <= in_h;
        a_inj_v   <= in_inj_v;
        a_inj_pos <= bus.inj_pos;
      end
    end
  end

  // Stage B combinational: check bits and flip masks.
  logic [7:0]  b_chk;
  logic [31:0] b_data_flip;
  logic [7:0]  b_chk_flip;

  always_comb begin
    b_chk       = '0;
    b_data_flip = '0;
    b_chk_flip  = '0;

    b_chk[0] = a_g[4] ^ a_g[5] ^ a_c[0];
    b_chk[1] = a_g[6] ^ a_g[7] ^ a_c[1];
    b_chk[2] = a_g[4] ^ a_g[6] ^ a_c[2];
    b_chk[3] = a_g[5] ^ a_g[7] ^ a_c[3];
    b_chk[4] = a_g[0] ^ a_g[1] ^ a_h[0];
    b_chk[5] = a_g[2] ^ a_g[3] ^ a_h[1];
    b_chk[6] = a_g[0] ^ a_g[2] ^ a_h[2];
    b_chk[7] = a_g[1] ^ a_g[3] ^ a_h[3];

    // Bit 5 of the position splits data (0..31) from check bits (32..39);
    // a_inj_v already excludes 40..63, so bits [4:3] are zero for chk flips.
    if (a_inj_v) begin
      if (a_inj_pos[5]) begin
        b_chk_flip = 8'b1 << a_inj_pos[2:0];
      end else begin
        b_data_flip = 32'b1 << a_inj_pos[4:0];
      end
    end
  end

  // Stage B registers (the output).
  logic        b_valid;
  logic [31:0] out_data_q;
  logic [7:0]  out_chk_q;
  logic [15:0] enc_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid    <= 1'b0;
      out_data_q <= '0;
      out_chk_q  <= '0;
    end else if (adv) begin
      b_valid <= a_valid;
      if (a_valid) begin
        out_data_q <= a_d ^ b_data_flip;
        out_chk_q  <= b_chk ^ b_chk_flip;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count_q <= '0;
    end else if (b_valid && bus.out_ready && (enc_count_q != 16'hFFFF)) begin
      enc_count_q <= enc_count_q + 16'd1;
    end
  end

  assign bus.out_valid = b_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_chk   = out_chk_q;
  assign bus.enc_count = enc_count_q;

endmodule

// File: tb/tb_sec_encoder32.sv
// tb_sec_encoder32
//   Self-checking bench for sec_encoder32: directed vectors with literal
//   expectations, a reset flush, backpressure, random streaming with
//   injections, and counter saturation. A scoreboard of expected codewords
//   (computed from the group/column parity definitions) is checked against
//   every output handshake.
module tb_sec_encoder32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sec_encoder32_if bus();

  sec_encoder32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference check bits straight from the parity definitions.
  function automatic logic [7:0] model_chk(input logic [31:0] d);
    logic [7:0] g;
    logic [3:0] c, h;
    logic [7:0] k;
    for (int i = 0; i < 8; i++) g[i] = d[4*i] ^ d[4*i+1] ^ d[4*i+2] ^ d[4*i+3];
    for (int j = 0; j < 4; j++) begin
      c[j] = d[j] ^ d[j+4] ^ d[j+8] ^ d[j+12];
      h[j] = d[16+j] ^ d[20+j] ^ d[24+j] ^ d[28+j];
    end
    k[0] = g[4] ^ g[5] ^ c[0];
    k[1] = g[6] ^ g[7] ^ c[1];
    k[2] = g[4] ^ g[6] ^ c[2];
    k[3] = g[5] ^ g[7] ^ c[3];
    k[4] = g[0] ^ g[1] ^ h[0];
    k[5] = g[2] ^ g[3] ^ h[1];
    k[6] = g[0] ^ g[2] ^ h[2];
    k[7] = g[1] ^ g[3] ^ h[3];
    return k;
  endfunction

  // Expected codeword as {data, chk}.
  function automatic logic [39:0] model_word(input logic [31:0] d, input logic ie, input logic [5:0] pos);
    logic [39:0] w;
    w = {d, model_chk(d)};
    if (ie && pos < 6'd32)      w[8 + int'(pos)] = ~w[8 + int'(pos)];
    else if (ie && pos < 6'd40) w[int'(pos) - 32] = ~w[int'(pos) - 32];
    return w;
  endfunction

  logic [39:0] exp_q[$];
  int          model_count = 0;

  // Scoreboard: inputs and outputs are stable at the falling edge, and each
  // handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("enc_count", 64'(bus.enc_count), 64'(model_count));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(bus.out_data), 64'hDEAD_BEEF_0000);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          check("sb_data", 64'(bus.out_data), 64'(e[39:8]));
          check("sb_chk",  64'(bus.out_chk),  64'(e[7:0]));
        end
        if (model_count != 16'hFFFF) model_count++;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model_word(bus.in_data, bus.inj_en, bus.inj_pos));
    end
  end

  // Present a word and hold it until it is accepted; returns #1 after the
  // accepting edge with the inputs still driven.
  task automatic send_word(input logic [31:0] d, input logic ie, input logic [5:0] pos);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.inj_en   = ie;
    bus.inj_pos  = pos;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.inj_en   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Single word, no other traffic: checks two-edge latency and literals.
  task automatic directed(input string name, input logic [31:0] d, input logic ie,
                          input logic [5:0] pos, input logic [31:0] xd, input logic [7:0] xc);
    @(posedge clk);
    #1;
    send_word(d, ie, pos);
    idle_inputs();
    check({name, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check({name, "_lat2_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_data"}, 64'(bus.out_data), 64'(xd));
    check({name, "_chk"},  64'(bus.out_chk),  64'(xc));
    @(posedge clk);
    #1;
    check({name, "_empty"}, 64'(bus.out_valid), 64'd0);
  endtask

  logic [31:0] held_data;
  logic [7:0]  held_chk;
  int          base_cnt;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.inj_en    = 1'b0;
    bus.inj_pos   = '0;
    bus.out_ready = 1'b1;

    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_enc_count", 64'(bus.enc_count), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Single-bit patterns and injection, literals computed by hand.
    directed("d0",      32'h0000_0000, 1'b0, 6'd0,  32'h0000_0000, 8'h00);
    directed("d1",      32'h0000_0001, 1'b0, 6'd0,  32'h0000_0001, 8'h51);
    directed("d16",     32'h0001_0000, 1'b0, 6'd0,  32'h0001_0000, 8'h15);
    directed("dff",     32'hFFFF_FFFF, 1'b0, 6'd0,  32'hFFFF_FFFF, 8'h00);
    directed("inj5",    32'h0000_0000, 1'b1, 6'd5,  32'h0000_0020, 8'h00);
    directed("inj33",   32'h0000_0000, 1'b1, 6'd33, 32'h0000_0000, 8'h02);
    directed("inj45",   32'h0000_0000, 1'b1, 6'd45, 32'h0000_0000, 8'h00);
    directed("inj_off", 32'h0000_0000, 1'b0, 6'd5,  32'h0000_0000, 8'h00);
    directed("inj39",   32'h0000_0001, 1'b1, 6'd39, 32'h0000_0001, 8'hD1);

    // Reset with two words in flight.
    @(posedge clk);
    #1;
    send_word(32'h1234_5678, 1'b0, 6'd0);
    send_word(32'h9ABC_DEF0, 1'b0, 6'd0);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check("rrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rrst_out_data",  64'(bus.out_data),  64'd0);
    check("rrst_out_chk",   64'(bus.out_chk),   64'd0);
    check("rrst_enc_count", 64'(bus.enc_count), 64'd0);
    check("rrst_in_ready",  64'(bus.in_ready),  64'd1);
    exp_q.delete();
    model_count = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rrst_no_ghost", 64'(bus.out_valid), 64'd0);
    end

    // Backpressure: four back-to-back words, output stalled 3 cycles.
    @(posedge clk);
    #1;
    fork
      begin
        send_word(32'hA5A5_0001, 1'b0, 6'd0);
        send_word(32'h0F0F_1234, 1'b1, 6'd7);
        send_word(32'hCAFE_BABE, 1'b1, 6'd36);
        send_word(32'h8000_0000, 1'b0, 6'd0);
        idle_inputs();
      end
      begin
        int cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        check("bp_first_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        held_data = bus.out_data;
        held_chk  = bus.out_chk;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_in_ready",  64'(bus.in_ready),  64'd0);
          check("bp_out_valid", 64'(bus.out_valid), 64'd1);
          check("bp_hold_data", 64'(bus.out_data),  64'(held_data));
          check("bp_hold_chk",  64'(bus.out_chk),   64'(held_chk));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_enc_count", 64'(bus.enc_count), 64'd4);

    // Random stream with random injections and random output stalls.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [5:0] p;
          p = 6'($urandom_range(0, 63));
          send_word($urandom, 1'($urandom_range(0, 1)), p);
          if ($urandom_range(0, 3) == 0) begin
            idle_inputs();
            @(posedge clk);
            #1;
          end
        end
        idle_inputs();
      end
      begin
        for (int i = 0; i < 900; i++) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("rand_drain");

    // Counter saturation: continuous streaming past 65535 handshakes.
    base_cnt = int'(bus.enc_count);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.inj_en   = 1'b0;
    for (int i = 0; i < 65545 - base_cnt + 4; i++) begin
      bus.in_data = $urandom;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    wait_drain("sat_drain");
    check("sat_enc_count", 64'(bus.enc_count), 64'hFFFF);
    directed("sat_after", 32'h0000_0001, 1'b0, 6'd0, 32'h0000_0001, 8'h51);
    check("sat_hold", 64'(bus.enc_count), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
